// File: rtl/csa_mp_sequencer.sv
// Multi-precision add/subtract sequencer: streams NUM_WORDS 16-bit word pairs,
// LS word first, through one shared 16-bit carry-select adder.

module CarrySelectAdder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);
  // Four 4-bit blocks; each precomputes both carry-in cases, the incoming carry selects.
  always_comb begin
    logic [4:0] s0;
    logic [4:0] s1;
    logic       c;
    c   = Cin;
    Sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      s0 = {1'b0, A[4*i +: 4]} + {1'b0, B[4*i +: 4]};
      s1 = {1'b0, A[4*i +: 4]} + {1'b0, B[4*i +: 4]} + 5'd1;
      Sum[4*i +: 4] = c ? s1[3:0] : s0[3:0];
      c = c ? s1[4] : s0[4];
    end
    Cout = c;
  end
endmodule

module csa_mp_sequencer #(
  parameter int NUM_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic        cin_ext,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic        done,
  output logic        cout_final,
  output logic        zero_final,
  output logic        ovf_final
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t      state;
  logic        sub_q;
  logic        carry_q;
  logic [3:0]  cnt;
  logic        zero_acc;
  logic        ovf_q;

  logic [15:0] b_eff;
  logic [15:0] sum;
  logic        cout;
  logic        accept;
  logic        last_word;

  assign b_eff     = sub_q ? ~in_b : in_b;
  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_word = (cnt == 4'(NUM_WORDS - 1));

  CarrySelectAdder u_add (
    .A   (in_a),
    .B   (b_eff),
    .Cin (carry_q),
    .Sum (sum),
    .Cout(cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      cnt        <= '0;
      zero_acc   <= 1'b0;
      ovf_q      <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      cout_final <= 1'b0;
      zero_final <= 1'b0;
      ovf_final  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            carry_q    <= sub ? 1'b1 : cin_ext;
            sub_q      <= sub;
            cnt        <= '0;
            zero_acc   <= 1'b1;
            ovf_q      <= 1'b0;
            cout_final <= 1'b0;
            zero_final <= 1'b0;
            ovf_final  <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            out_sum   <= sum;
            out_valid <= 1'b1;
            out_idx   <= cnt;
            carry_q   <= cout;
            zero_acc  <= zero_acc & (sum == 16'h0000);
            if (last_word) begin
              // Carry into bit 15 XOR carry out of bit 15.
              out_last <= 1'b1;
              ovf_q    <= in_a[15] ^ b_eff[15] ^ sum[15] ^ cout;
              state    <= FLUSH;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b1;
            cout_final <= carry_q;
            zero_final <= zero_acc;
            ovf_final  <= ovf_q;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/csa_mp_sequencer.md
Name: csa_mp_sequencer

Overview:
- Multi-precision add/subtract sequencer built around one shared 16-bit CarrySelectAdder instance (ports A, B, Cin, Sum, Cout).
- Streams NUM_WORDS 16-bit operand word pairs, least-significant word first, through the adder, one word per cycle.
- Registers the inter-word carry between words and reports final carry/borrow, zero and signed-overflow flags.
- Gives the datapath wide (up to 256-bit) arithmetic without widening the adder.

Parameters:
- NUM_WORDS, 4, number of 16-bit words per operand; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins an operation; accepted only in IDLE.
- sub  input  1  sampled with start: 0 = A+B, 1 = A-B.
- cin_ext  input  1  sampled with start: initial carry for add; ignored when sub=1.
- busy  output  1  high whenever state is not IDLE.
- in_valid  input  1  operand word pair valid.
- in_ready  output  1  block accepts an operand word this cycle.
- in_a  input  16  operand A word.
- in_b  input  16  operand B word.
- out_valid  output  1  result word valid.
- out_ready  input  1  consumer accepts the result word.
- out_sum  output  16  result word.
- out_idx  output  4  word index of out_sum (0 = least significant).
- out_last  output  1  out_sum is the most-significant word.
- done  output  1  one-cycle pulse when the final word has been accepted.
- cout_final  output  1  final carry-out; for sub, 1 = no borrow.
- zero_final  output  1  all result words were 0000.
- ovf_final  output  1  two's-complement overflow of the full-width result.

Behaviour:
- Reset: state IDLE. busy, in_ready, out_valid, out_sum, out_idx, out_last, done, cout_final, zero_final and ovf_final are all 0. Internal carry, word counter and zero accumulator are cleared.
- Reset mid-operation aborts immediately: out_valid drops, no done pulse, and all partial results are discarded.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - On start: carry_q <= sub ? 1 : cin_ext; latch sub; word counter <= 0; zero_acc <= 1; cout_final, zero_final and ovf_final <= 0; go to RUN.
- start while busy is ignored.
- RUN:
  - in_ready = !out_valid || out_ready (single output register, no skid buffer).
  - Word accepted when in_valid && in_ready. Adder inputs: A=in_a, B = sub ? ~in_b : in_b, Cin=carry_q.
  - On acceptance, next edge: out_sum <= Sum; out_valid <= 1; out_idx <= counter; carry_q <= Cout; zero_acc &= (Sum==0); counter++.
  - If counter == NUM_WORDS-1: out_last <= 1; capture ovf = in_a[15] ^ B[15] ^ Sum[15] ^ Cout (carry into bit 15 XOR carry out); go to FLUSH.
  - If out_valid && out_ready with no new acceptance, out_valid <= 0.
- Latency and throughput:
  - A word accepted in cycle k appears on out_sum in cycle k+1.
  - Sustained throughput is 1 word/cycle while out_ready=1.
  - While out_valid && !out_ready, out_sum, out_idx and out_last are held stable and in_ready=0.
- FLUSH:
  - in_ready=0.
  - When out_valid && out_ready: out_valid <= 0, out_last <= 0, done <= 1 for one cycle. cout_final <= carry_q, zero_final <= zero_acc, ovf_final <= captured ovf. Return to IDLE.
- cout_final, zero_final and ovf_final hold until the next accepted start or reset.
- Counter wrap never occurs; the counter is bounded by NUM_WORDS-1 and reset to 0 on start.
- Gaps in in_valid are allowed. The carry is held across idle cycles, with no timeout.

Test Plan:
- NUM_WORDS=4, add, cin_ext=1, all A words FFFF, all B words 0000 -> four out_sum=0000 (idx 0..3, out_last on idx 3), cout_final=1, zero_final=1, ovf_final=0, done one pulse.
- Sub, A = 0000_0000_0000_0001, B = 0000_0000_0000_0002 -> four out_sum=FFFF, cout_final=0 (borrow), zero_final=0, ovf_final=0.
- Add, cin_ext=0, word0 2AD5+9E45, upper words 0 -> idx0 out_sum=C91A; then 0000 x3; cout_final=0; zero_final=0.
- Add, lower words 0000, MS word 7FFF+0001 -> MS out_sum=8000, ovf_final=1, cout_final=0.
- Backpressure: out_ready=0 for 3 cycles after the first result -> in_ready=0, out_sum and out_idx stable. On release, remaining words complete; results match the no-stall run.
- Reset asserted after 2 words accepted -> next cycle busy=0, out_valid=0, no done. Start asserted while busy -> ignored. A fresh start then completes correctly.
